des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key schedule that sits directly upstream of the 16-round stack. It accepts one 64-bit key per valid/ready handshake, generates the sixteen 48-bit subkeys one per clock (PC-1, per-round left rotations, PC-2 per FIPS 46-3), and presents them as the packed `round_keys` array the round stack consumes. Subkeys are stored in encryption or decryption order, selected per key, so the round stack itself never changes.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `key`  in  64  DES key; bit 63 = FIPS bit 1, bit 0 = FIPS bit 64. Parity bits (FIPS 8,16,…,64, i.e. bit 0 of each byte) are ignored.
- `decrypt`  in  1  sampled with `key`; 1 = store subkeys in reversed order.
- `key_valid`  in  1  upstream offers `key`/`decrypt`.
- `key_ready`  out  1  block can accept a key; equals (state == IDLE).
- `round_keys`  out  [0:15][47:0]  subkey array; index i is consumed by round stage i. Bit 47 = PC-2 output bit 1.
- `keys_valid`  out  1  `round_keys` holds the complete set for the last accepted key.
- `busy`  out  1  equals (state == GEN).

## Operation
- Registers: `state` {IDLE, GEN}; 28-bit `C`, `D`; 4-bit round counter `rnd`; `dec` flag; 16×48 subkey store driving `round_keys`; `keys_valid`.
- Acceptance: `key_valid && key_ready && !rst` at an edge. On accept: `{C,D} <= PC1(key)`, `dec <= decrypt`, `rnd <= 0`, `keys_valid <= 0`, state -> GEN.
- GEN, each cycle:
  - Shift amount s = 1 for rnd ∈ {0,1,8,15}, otherwise 2.
  - `C' = rotl28(C,s)`, `D' = rotl28(D,s)`, `K = PC2({C',D'})`.
  - Write K into slot `dec ? 15-rnd : rnd`; `C,D <= C',D'`; `rnd <= rnd+1`.
  - At rnd == 15: state -> IDLE, `keys_valid <= 1`. Total rotation is 28, so C and D return to their PC-1 values.
- In IDLE, `C`, `D`, the store and `keys_valid` hold. `round_keys` is stable for as long as `keys_valid` = 1.
- `key_valid` while GEN: ignored. `key_ready` = 0, and upstream must hold `key`/`decrypt` until accepted.
- Accept in the same cycle that `keys_valid` is 1: legal. `keys_valid` drops on that edge and the old set begins to be overwritten slot by slot.
- Slots not yet rewritten during GEN keep stale values. Consumers must qualify `round_keys` with `keys_valid`.

## Timing
- Reset (`rst` high at an edge): state = IDLE, `rnd` = 0, `C` = `D` = 0, all slots = 0, `keys_valid` = 0, `dec` = 0. After the reset edge, `key_ready` = 1 and `busy` = 0.
- Reset wins over a simultaneous handshake: no key is accepted on a reset edge.
- Reset mid-GEN aborts generation. Outputs go to the reset values above, and the partial set is discarded (slots zeroed).
- Latency: key accepted at edge N. Slots are written at edges N+1 … N+16. `keys_valid` and `key_ready` go high after edge N+16.
- Throughput: one key per 17 cycles at best (accept edge plus 16 generation edges). Back-to-back accept is possible on the edge where `keys_valid` rises.
- `key_ready`/`busy` are decoded directly from state, with no combinational path from `key_valid`.

## Test plan
- **Known vector.** Encrypt, key 0x133457799BBCDFF1.
  - `keys_valid` rises exactly 16 cycles after acceptance.
  - `round_keys[0]` = 0x1B02EFFC7072, `[1]` = 0x79AED9DBC9E5, `[15]` = 0xCB3D8B0E17F5.
  - All 16 slots match a reference model.
- **Decrypt order.** Same key, `decrypt` = 1.
  - `round_keys[0]` = 0xCB3D8B0E17F5, `[14]` = 0x79AED9DBC9E5, `[15]` = 0x1B02EFFC7072.
- **Parity and weak keys.**
  - Keys 0x0000000000000000 and 0x0101010101010101 both give all slots = 0x000000000000.
  - Key 0xFEFEFEFEFEFEFEFE gives all slots = 0xFFFFFFFFFFFF.
- **Handshake.**
  - Hold `key_valid` = 1 with a second key during GEN. The second key must not be accepted until the edge where `keys_valid` rises.
  - `key_ready` = 0 for exactly 16 cycles.
  - The second set is correct.
- **Reset mid-operation.**
  - Assert `rst` 7 cycles after acceptance: next cycle `keys_valid` = 0, `busy` = 0, `key_ready` = 1, all slots = 0.
  - A fresh key afterwards produces correct subkeys.
- **Reset/accept collision.** `key_valid` = 1 on the reset edge: no acceptance, `busy` = 0 afterwards.

Source files
------------

// File: rtl/des_key_schedule_if.sv
// des_key_schedule_if
// Handshake and subkey bundle between the key source, the key schedule and
// the 16-round stack.
//   key        [63:0]  DES key, bit 63 = FIPS bit 1 (parity bits ignored)
//   decrypt            1 = store subkeys in reversed order
//   key_valid          upstream offers key/decrypt
//   key_ready          schedule can accept a key (idle)
//   round_keys [0:15][47:0]  subkey array, slot i feeds round stage i
//   keys_valid         round_keys holds the complete set for the last key
//   busy               schedule is generating subkeys
// master = key source side, slave = key schedule side.
interface des_key_schedule_if;
    logic [63:0]       key;
    logic              decrypt;
    logic              key_valid;
    logic              key_ready;
    logic [0:15][47:0] round_keys;
    logic              keys_valid;
    logic              busy;

    modport master (
        output key, decrypt, key_valid,
        input  key_ready, round_keys, keys_valid, busy
    );

    modport slave (
        input  key, decrypt, key_valid,
        output key_ready, round_keys, keys_valid, busy
    );
endinterface

// File: rtl/des_key_schedule.sv
// des_key_schedule
// Sequential DES key schedule. Accepts one 64-bit key per handshake, then
// produces one 48-bit subkey per clock for 16 clocks (PC-1, left rotations,
// PC-2) into a 16-slot store that drives the round stack directly. With
// decrypt set the subkeys land in reversed slot order.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   des_key_schedule_if.slave (key/decrypt/key_valid in,
//         key_ready/round_keys/keys_valid/busy out)
module des_key_schedule (
    input logic               clk,
    input logic               rst,
    des_key_schedule_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Permuted choice 1: FIPS key bit numbers (1 = MSB) for C1..C28, D1..D28.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: CD bit numbers (1 = MSB of {C,D}) for subkey bits 1..48.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] res;
        res = '0;
        for (int i = 0; i < 56; i++) begin
            res[6'(55 - i)] = k[6'(64 - PC1_TAB[6'(i)])];
        end
        return res;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] res;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            res[6'(47 - i)] = cd[6'(56 - PC2_TAB[6'(i)])];
        end
        return res;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    state_t            state;
    state_t            state_next;
    logic [27:0]       c_half;
    logic [27:0]       d_half;
    logic [3:0]        rnd;
    logic              dec;
    logic [0:15][47:0] key_store;
    logic              keys_valid;

    logic              accept;
    logic              shift_two;
    logic [27:0]       c_next;
    logic [27:0]       d_next;
    logic [47:0]       subkey;
    logic [3:0]        slot;

    // Handshake completes only from IDLE; reset priority is handled in the
    // sequential blocks, which test rst before accept.
    assign accept = bus.key_valid && (state == IDLE);

    // Rounds 1, 2, 9 and 16 rotate by one, all others by two; the total of 28
    // brings C and D back to their PC-1 values at the end of a set.
    assign shift_two = !((rnd == 4'd0) || (rnd == 4'd1) || (rnd == 4'd8) || (rnd == 4'd15));
    assign c_next    = rotl28(c_half, shift_two);
    assign d_next    = rotl28(d_half, shift_two);
    assign subkey    = pc2({c_next, d_next});

    // Reversed order for decryption: 15 - rnd is the bitwise inverse of rnd.
    assign slot      = dec ? ~rnd : rnd;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE leaves on a handshake, GEN returns after the
    // sixteenth subkey.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.key_valid) state_next = GEN;
            GEN:  if (rnd == 4'd15)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load PC-1 on accept, then rotate and write one slot per cycle.
    // Reset clears the store so an aborted partial set never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_half     <= '0;
            d_half     <= '0;
            rnd        <= '0;
            dec        <= 1'b0;
            key_store  <= '0;
            keys_valid <= 1'b0;
        end else if (accept) begin
            {c_half, d_half} <= pc1(bus.key);
            dec              <= bus.decrypt;
            rnd              <= '0;
            keys_valid       <= 1'b0;
        end else if (state == GEN) begin
            key_store[slot] <= subkey;
            c_half          <= c_next;
            d_half          <= d_next;
            rnd             <= rnd + 4'd1;
            if (rnd == 4'd15) begin
                keys_valid <= 1'b1;
            end
        end
    end

    assign bus.key_ready  = (state == IDLE);
    assign bus.busy       = (state == GEN);
    assign bus.round_keys = key_store;
    assign bus.keys_valid = keys_valid;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule
// Self-checking bench for des_key_schedule. Subkeys are predicted by a
// reference model that computes each round's C/D directly from the
// cumulative rotation amount over bit-numbered arrays, then applies PC-2.
// Directed steps cover reset, the FIPS worked example, decrypt order, weak
// and parity-only keys, random keys, held handshake, mid-run reset and a
// reset/accept collision.
module tb_des_key_schedule;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    des_key_schedule_if bus ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pc1_tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int pc2_tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Subkey for round r (0-based) straight from the FIPS description.
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
        logic        cd0 [1:56];
        logic        cd  [1:56];
        logic [47:0] res;
        int          s;
        s = 0;
        for (int i = 0; i <= r; i++) s += shifts[i];
        for (int j = 1; j <= 56; j++) cd0[j] = k[64 - pc1_tab[j-1]];
        for (int j = 1; j <= 28; j++) begin
            cd[j]      = cd0[((j - 1 + s) % 28) + 1];
            cd[28 + j] = cd0[28 + ((j - 1 + s) % 28) + 1];
        end
        for (int m = 1; m <= 48; m++) res[48 - m] = cd[pc2_tab[m-1]];
        return res;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Compare all 16 slots against the model for the given key/order.
    task automatic check_set(input string tag, input logic [63:0] k, input logic d);
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("%s_slot%0d", tag, i), 64'(bus.round_keys[i]),
                         64'(model_subkey(k, d ? 15 - i : i)));
        end
    endtask

    task automatic check_all_slots(input string tag, input logic [47:0] value);
        for (int i = 0; i < 16; i++) begin
            check_output($sformatf("%s_slot%0d", tag, i), 64'(bus.round_keys[i]), 64'(value));
        end
    endtask

    // Present a key while idle and complete the handshake; returns just after
    // the accept edge with key_valid dropped.
    task automatic apply_stimulus(input logic [63:0] k, input logic d, input string tag);
        bus.key       = k;
        bus.decrypt   = d;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        check_output({tag, "_accepted_busy"}, 64'(bus.busy), 64'd1);
    endtask

    // Count edges until keys_valid rises, bounded.
    task automatic wait_done(output int latency);
        latency = 0;
        while (latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
            if (bus.keys_valid) break;
        end
    endtask

    task automatic run_key(input logic [63:0] k, input logic d, input string tag);
        int lat;
        apply_stimulus(k, d, tag);
        wait_done(lat);
        check_output({tag, "_latency"}, 64'(lat), 64'd16);
        check_set(tag, k, d);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] ka;
        logic [63:0] kb;
        logic        da;
        logic        db;
        int          low;
        int          lat;

        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        bus.key       = '0;
        bus.decrypt   = 1'b0;
        bus.key_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_output("rst_key_ready", 64'(bus.key_ready), 64'd1);
        check_output("rst_busy", 64'(bus.busy), 64'd0);
        check_output("rst_keys_valid", 64'(bus.keys_valid), 64'd0);
        check_all_slots("rst", 48'h0);

        // FIPS worked example, encrypt order
        run_key(64'h133457799BBCDFF1, 1'b0, "enc");
        check_output("enc_k0", 64'(bus.round_keys[0]), 64'h1B02EFFC7072);
        check_output("enc_k1", 64'(bus.round_keys[1]), 64'h79AED9DBC9E5);
        check_output("enc_k15", 64'(bus.round_keys[15]), 64'hCB3D8B0E17F5);
        check_output("enc_key_ready", 64'(bus.key_ready), 64'd1);

        // Same key, decrypt order
        run_key(64'h133457799BBCDFF1, 1'b1, "dec");
        check_output("dec_k0", 64'(bus.round_keys[0]), 64'hCB3D8B0E17F5);
        check_output("dec_k14", 64'(bus.round_keys[14]), 64'h79AED9DBC9E5);
        check_output("dec_k15", 64'(bus.round_keys[15]), 64'h1B02EFFC7072);

        // Weak and parity-only keys
        run_key(64'h0000000000000000, 1'b0, "zero");
        check_all_slots("zero_const", 48'h0);
        run_key(64'h0101010101010101, 1'b1, "parity");
        check_all_slots("parity_const", 48'h0);
        run_key(64'hFEFEFEFEFEFEFEFE, 1'b0, "ones");
        check_all_slots("ones_const", 48'hFFFFFFFFFFFF);

        // Random keys and directions
        for (int n = 0; n < 5; n++) begin
            ka = {$urandom, $urandom};
            da = 1'($urandom_range(0, 1));
            run_key(ka, da, $sformatf("rand%0d", n));
        end

        // Held handshake: second key offered throughout generation
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        da = 1'b0;
        db = 1'b1;
        apply_stimulus(ka, da, "hs_a");
        bus.key       = kb;
        bus.decrypt   = db;
        bus.key_valid = 1'b1;
        low = 0;
        while (low < 40 && !bus.key_ready) begin
            low++;
            @(posedge clk);
            #1;
        end
        check_output("hs_ready_low_cycles", 64'(low), 64'd16);
        check_output("hs_a_keys_valid", 64'(bus.keys_valid), 64'd1);
        check_set("hs_a", ka, da);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        check_output("hs_b_accept_busy", 64'(bus.busy), 64'd1);
        check_output("hs_b_keys_valid_drop", 64'(bus.keys_valid), 64'd0);
        wait_done(lat);
        check_output("hs_b_latency", 64'(lat), 64'd16);
        check_set("hs_b", kb, db);

        // Reset seven cycles after acceptance
        ka = {$urandom, $urandom};
        apply_stimulus(ka, 1'b0, "mid");
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("mid_keys_valid", 64'(bus.keys_valid), 64'd0);
        check_output("mid_busy", 64'(bus.busy), 64'd0);
        check_output("mid_key_ready", 64'(bus.key_ready), 64'd1);
        check_all_slots("mid_cleared", 48'h0);
        kb = {$urandom, $urandom};
        run_key(kb, 1'b1, "after_mid");

        // Reset and handshake on the same edge
        bus.key       = {$urandom, $urandom};
        bus.key_valid = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        check_output("coll_busy", 64'(bus.busy), 64'd0);
        check_output("coll_key_ready", 64'(bus.key_ready), 64'd1);
        check_output("coll_keys_valid", 64'(bus.keys_valid), 64'd0);
        @(posedge clk);
        #1;
        check_output("coll_still_idle", 64'(bus.busy), 64'd0);
        check_all_slots("coll", 48'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
